lse_lut_loader: RTL
===================

Name: lse_lut_loader

Overview:
- Producer side of the LSE correction-LUT interface.
- Accepts burst writes of correction entries from the config/instruction path into a shadow table.
- Atomically commits the shadow table to the active table driven on o_lut_table, which feeds every lse_add/einsum_add consumer.
- Commit happens only while the datapath reports idle, so no adder ever sees a half-updated table.

Parameters:
- LUT_SIZE, 16, number of LUT entries; power of two.
- LUT_PRECISION, 12, bits per entry.
- IDX_W, $clog2(LUT_SIZE), entry index width; derived, not overridden.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_cfg_start  in  1  single-cycle burst-start request.
- i_cfg_base  in  IDX_W  first entry index of the burst.
- i_cfg_len  in  IDX_W+1  beat count; legal range 1..LUT_SIZE.
- i_abort  in  1  cancel the burst in progress.
- i_data_valid  in  1  data beat valid.
- i_data  in  LUT_PRECISION  entry value.
- o_data_ready  out  1  loader accepts a beat.
- i_pipe_idle  in  1  all LUT consumers idle; commit permitted.
- o_busy  out  1  state is not IDLE.
- o_done  out  1  one-cycle pulse after commit.
- o_err  out  1  one-cycle pulse on an illegal request.
- o_lut_table  out  LUT_PRECISION x [LUT_SIZE]  active table, registered.

Behaviour:
- Reset (async, i_rst=1): all o_lut_table entries and all shadow entries 0; o_data_ready, o_busy, o_done, o_err all 0; state IDLE; counters 0.
- State machine: IDLE -> LOAD -> WAIT_COMMIT -> IDLE.
- IDLE, i_cfg_start=1 with 1<=i_cfg_len<=LUT_SIZE:
  - latch write pointer = i_cfg_base and remaining = i_cfg_len;
  - go to LOAD; o_data_ready=1 from the next cycle.
- IDLE, i_cfg_start=1 with i_cfg_len=0 or i_cfg_len>LUT_SIZE: o_err pulses the next cycle; stay IDLE.
- i_cfg_start while not IDLE: ignored, o_err pulses the next cycle, burst unaffected.
- Beat handshake: a beat is accepted when i_data_valid && o_data_ready.
  - Accepted beat writes shadow[ptr] <= i_data, then ptr <= ptr+1 modulo LUT_SIZE (wraps 15->0 at default), remaining decrements.
  - o_data_ready is 1 only in LOAD. Beats presented in IDLE or WAIT_COMMIT are ignored.
- Last beat (remaining=1 and accepted): go to WAIT_COMMIT; o_data_ready=0 the next cycle.
- WAIT_COMMIT: on an edge with i_pipe_idle=1:
  - all entries copy shadow -> o_lut_table simultaneously;
  - o_done=1 for exactly the following cycle; return to IDLE.
- WAIT_COMMIT with i_pipe_idle=0: wait indefinitely; o_lut_table unchanged.
- Latency: with i_pipe_idle held 1, o_lut_table updates 1 cycle after the last-beat edge. o_done is high in the same cycle the new table is visible.
- i_abort in LOAD or WAIT_COMMIT: return to IDLE next cycle; shadow <= o_lut_table (discard partial writes); no o_done; active table unchanged.
- i_abort and commit condition in the same cycle: abort wins.
- i_abort in IDLE: no effect.
- Entries outside the burst range keep their prior shadow (= active) value.
- o_busy = (state != IDLE), registered with the state.
- Reset asserted mid-burst: everything returns to reset values immediately, including zeroing the active table.

Optional Feature:
- Macro: LSE_LUT_READBACK_EN.
- When defined:
  - adds ports i_rd_en (in, 1), i_rd_idx (in, IDX_W), o_rd_data (out, LUT_PRECISION), o_rd_valid (out, 1);
  - i_rd_en=1 returns active-table entry i_rd_idx on o_rd_data with o_rd_valid=1 one cycle later;
  - o_rd_data holds its value otherwise; reset value 0.
  - A read in the same cycle as a commit returns the pre-commit value.
- When undefined: these ports and their logic are absent.

Test Plan:
- Reset, then full load: base=0, len=16, data=i*100 for i=0..15, i_pipe_idle=1 -> o_lut_table[i]=i*100; o_done pulses once; o_busy falls on the same cycle.
- Wrap: base=14, len=4, data A,B,C,D -> entries 14,15,0,1 = A,B,C,D; entries 2..13 unchanged.
- Commit gating: hold i_pipe_idle=0 for 10 cycles after the last beat -> o_lut_table unchanged and o_data_ready=0 throughout; o_lut_table updates 1 cycle after i_pipe_idle=1.
- Abort: base=3, len=5, abort after 2 beats -> active unchanged, no o_done. A subsequent base=3, len=1, data=7 commit changes only entry 3, proving the shadow was restored.
- Errors: len=0 -> o_err single pulse, o_busy stays 0. i_cfg_start during LOAD -> o_err pulse and the burst still completes correctly.
- Backpressure/valid gaps: random i_data_valid=0 gaps within a len=8 burst -> exactly 8 entries written in order; o_done after the 8th beat only.

Source files
------------

// File: rtl/lse_lut_loader.sv
// LSE correction-LUT loader: burst writes into a shadow table, then an atomic
// shadow -> active commit taken only while every LUT consumer reports idle.
// Optional feature: define LSE_LUT_READBACK_EN to add a registered read port
// on the active table.
module lse_lut_loader #(
  parameter int LUT_SIZE      = 16,
  parameter int LUT_PRECISION = 12,
  localparam int IDX_W        = $clog2(LUT_SIZE)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cfg_start,
  input  logic [IDX_W-1:0]         i_cfg_base,
  input  logic [IDX_W:0]           i_cfg_len,
  input  logic                     i_abort,
  input  logic                     i_data_valid,
  input  logic [LUT_PRECISION-1:0] i_data,
  output logic                     o_data_ready,
  input  logic                     i_pipe_idle,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
`ifdef LSE_LUT_READBACK_EN
  input  logic                     i_rd_en,
  input  logic [IDX_W-1:0]         i_rd_idx,
  output logic [LUT_PRECISION-1:0] o_rd_data,
  output logic                     o_rd_valid,
`endif
  output logic [LUT_PRECISION-1:0] o_lut_table [LUT_SIZE]
);

  typedef enum logic [1:0] {StIdle, StLoad, StWaitCommit} state_e;

  localparam logic [IDX_W:0]   LenMax = (IDX_W+1)'(LUT_SIZE);
  localparam logic [IDX_W:0]   RemOne = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] PtrOne = IDX_W'(1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [IDX_W:0]             rem_q, rem_d;
  logic [LUT_PRECISION-1:0]   shadow_q [LUT_SIZE];
  logic [LUT_PRECISION-1:0]   shadow_d [LUT_SIZE];
  logic [LUT_PRECISION-1:0]   lut_q    [LUT_SIZE];
  logic [LUT_PRECISION-1:0]   lut_d    [LUT_SIZE];
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic len_ok;
  logic accept;
  logic abort;
  logic commit;

  assign len_ok = (i_cfg_len != '0) && (i_cfg_len <= LenMax);
  assign accept = i_data_valid && (state_q == StLoad);
  assign abort  = i_abort && (state_q != StIdle);
  // Abort beats a simultaneous commit so the active table stays untouched.
  assign commit = (state_q == StWaitCommit) && i_pipe_idle && !i_abort;

  // State and datapath registers; reset also clears the active table.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < LUT_SIZE; i++) begin
        shadow_q[i] <= '0;
        lut_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      lut_q    <= lut_d;
    end
  end

  // Next-state logic: IDLE -> LOAD -> WAIT_COMMIT -> IDLE, abort to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_cfg_start && len_ok) state_d = StLoad;
      end
      StLoad: begin
        if (i_abort)                          state_d = StIdle;
        else if (accept && (rem_q == RemOne)) state_d = StWaitCommit;
      end
      StWaitCommit: begin
        if (i_abort || i_pipe_idle) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values: pointer/count, shadow writes, commit.
  always_comb begin
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    shadow_d = shadow_q;
    lut_d    = lut_q;
    if ((state_q == StIdle) && i_cfg_start && len_ok) begin
      ptr_d = i_cfg_base;
      rem_d = i_cfg_len;
    end
    if (abort) begin
      // Discard partial writes: shadow re-mirrors the active table.
      shadow_d = lut_q;
    end else if (accept) begin
      shadow_d[ptr_q] = i_data;
      ptr_d           = ptr_q + PtrOne;
      rem_d           = rem_q - RemOne;
    end
    if (commit) lut_d = shadow_q;
    busy_d = (state_d != StIdle);
    done_d = commit;
    err_d  = i_cfg_start && ((state_q != StIdle) || !len_ok);
  end

  assign o_data_ready = (state_q == StLoad);
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_lut_table  = lut_q;

`ifdef LSE_LUT_READBACK_EN
  logic [LUT_PRECISION-1:0] rd_data_q;
  logic                     rd_valid_q;

  // Registered readback of the active table; sees pre-commit contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= i_rd_en;
      if (i_rd_en) rd_data_q <= lut_q[i_rd_idx];
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
`endif

endmodule
